// File: rtl/dcache_nway_wb.sv
//============================================================================
// Module   : dcache_nway_wb
// Purpose  : N-way set-associative, write-back, write-allocate data cache.
//            One outstanding CPU request. Misses evict a victim (lowest
//            invalid way, else a per-set round-robin pointer), write it back
//            if dirty, refill the whole line, then replay the lookup.
// Ports    : clk_i, rst_ni                  - clock, async active-low reset
//            cpu_req_* / cpu_resp_*         - CPU valid/ready request/response
//            mem_req_* / mem_resp_*         - line-granular memory port
//            hit_cnt_o, miss_cnt_o          - saturating statistics counters
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module dcache_nway_wb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BYTES = 16,
  parameter int WAYS       = 2,
  parameter int SETS       = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cpu_req_valid_i,
  output logic                    cpu_req_ready_o,
  input  logic                    cpu_we_i,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr_i,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cpu_wstrb_i,
  output logic                    cpu_resp_valid_o,
  input  logic                    cpu_resp_ready_i,
  output logic [DATA_WIDTH-1:0]   cpu_resp_rdata_o,
  output logic                    mem_req_valid_o,
  input  logic                    mem_req_ready_i,
  output logic                    mem_req_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr_o,
  output logic [LINE_BYTES*8-1:0] mem_req_wdata_o,
  input  logic                    mem_resp_valid_i,
  input  logic [LINE_BYTES*8-1:0] mem_resp_rdata_i,
  output logic [31:0]             hit_cnt_o,
  output logic [31:0]             miss_cnt_o
);

  localparam int LINE_W   = LINE_BYTES * 8;
  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int OFFSET_W = $clog2(LINE_BYTES);
  localparam int INDEX_W  = $clog2(SETS);
  localparam int TAG_W    = ADDR_WIDTH - OFFSET_W - INDEX_W;
  localparam int BOFF_W   = $clog2(STRB_W);
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WRITEBACK, S_REFILL_REQ, S_REFILL_WAIT, S_RESPOND
  } state_e;

  state_e state_q, state_d;

  // Per-line storage; tag/data carry no reset since valid qualifies them.
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [WAY_W-1:0]  rr_q    [SETS];

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic                  replay_q;   // lookup after a refill: not counted
  logic [WAY_W-1:0]      victim_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [31:0]           hit_cnt_q, miss_cnt_q;

  logic [TAG_W-1:0]    w_tag;
  logic [INDEX_W-1:0]  w_index;
  logic [OFFSET_W-1:0] w_word;
  logic                w_hit, w_has_inv;
  logic [WAY_W-1:0]    w_hit_way, w_inv_way, w_victim;
  logic [LINE_W-1:0]   w_hit_line, w_merged;
  logic [DATA_WIDTH-1:0] w_hit_word;
  int                  w_word_base;

  assign w_tag   = addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign w_index = addr_q[OFFSET_W +: INDEX_W];
  assign w_word  = addr_q[OFFSET_W-1:0] >> BOFF_W;

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_has_inv = 1'b0;
    w_inv_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w_index][w] && (tag_q[w_index][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
    // Descending scan so the last match is the lowest invalid way.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w_index][w]) begin
        w_has_inv = 1'b1;
        w_inv_way = WAY_W'(w);
      end
    end
    w_victim = w_has_inv ? w_inv_way : rr_q[w_index];
  end

  // Hit word extraction and byte-enable merge for stores.
  always_comb begin
    w_word_base = int'(w_word) * DATA_WIDTH;
    w_hit_line  = data_q[w_index][w_hit_way];
    w_hit_word  = w_hit_line[w_word_base +: DATA_WIDTH];
    w_merged    = w_hit_line;
    for (int b = 0; b < STRB_W; b++) begin
      if (wstrb_q[b]) w_merged[w_word_base + b*8 +: 8] = wdata_q[b*8 +: 8];
    end
  end

  // Next-state logic and memory-side outputs.
  always_comb begin
    state_d         = state_q;
    mem_req_valid_o = 1'b0;
    mem_req_we_o    = 1'b0;
    mem_req_addr_o  = '0;
    mem_req_wdata_o = '0;
    case (state_q)
      S_IDLE:       if (cpu_req_valid_i) state_d = S_LOOKUP;
      S_LOOKUP: begin
        if (w_hit)
          state_d = S_RESPOND;
        else if (valid_q[w_index][w_victim] && dirty_q[w_index][w_victim])
          state_d = S_WRITEBACK;
        else
          state_d = S_REFILL_REQ;
      end
      S_WRITEBACK: begin
        mem_req_valid_o = 1'b1;
        mem_req_we_o    = 1'b1;
        mem_req_addr_o  = {tag_q[w_index][victim_q], w_index, {OFFSET_W{1'b0}}};
        mem_req_wdata_o = data_q[w_index][victim_q];
        if (mem_req_ready_i) state_d = S_REFILL_REQ;
      end
      S_REFILL_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = {w_tag, w_index, {OFFSET_W{1'b0}}};
        if (mem_req_ready_i) state_d = S_REFILL_WAIT;
      end
      S_REFILL_WAIT: if (mem_resp_valid_i) state_d = S_LOOKUP;
      S_RESPOND:     if (cpu_resp_ready_i) state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  // Ready is qualified by reset so nothing is advertised while held in reset.
  assign cpu_req_ready_o  = rst_ni && (state_q == S_IDLE);
  assign cpu_resp_valid_o = (state_q == S_RESPOND);
  assign cpu_resp_rdata_o = rdata_q;
  assign hit_cnt_o        = hit_cnt_q;
  assign miss_cnt_o       = miss_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      replay_q   <= 1'b0;
      victim_q   <= '0;
      rdata_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && cpu_req_valid_i) begin
        addr_q   <= cpu_addr_i;
        we_q     <= cpu_we_i;
        wdata_q  <= cpu_wdata_i;
        wstrb_q  <= cpu_wstrb_i;
        replay_q <= 1'b0;
      end
      if (state_q == S_LOOKUP) begin
        if (w_hit) begin
          rdata_q <= we_q ? '0 : w_hit_word;
          if (we_q) dirty_q[w_index][w_hit_way] <= 1'b1;
          if (!replay_q && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
        end else begin
          victim_q <= w_victim;
          if (WAYS > 1 && !w_has_inv) rr_q[w_index] <= rr_q[w_index] + WAY_W'(1);
          if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
      end
      if (state_q == S_REFILL_WAIT && mem_resp_valid_i) begin
        valid_q[w_index][victim_q] <= 1'b1;
        dirty_q[w_index][victim_q] <= 1'b0;
        replay_q                   <= 1'b1;
      end
    end
  end

  // Tag/data arrays; writes are gated by the reset-controlled state.
  always_ff @(posedge clk_i) begin
    if (state_q == S_LOOKUP && w_hit && we_q)
      data_q[w_index][w_hit_way] <= w_merged;
    if (state_q == S_REFILL_WAIT && mem_resp_valid_i) begin
      data_q[w_index][victim_q] <= mem_resp_rdata_i;
      tag_q[w_index][victim_q]  <= w_tag;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dcache_nway_wb.sv
//============================================================================
// Module   : tb_dcache_nway_wb
// Purpose  : Directed self-checking bench for dcache_nway_wb (2 ways,
//            16-byte lines, 64 sets) with a small write-back-aware memory.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dcache_nway_wb;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         cpu_req_valid_i, cpu_req_ready_o, cpu_we_i;
  logic [31:0]  cpu_addr_i, cpu_wdata_i;
  logic [3:0]   cpu_wstrb_i;
  logic         cpu_resp_valid_o, cpu_resp_ready_i;
  logic [31:0]  cpu_resp_rdata_o;
  logic         mem_req_valid_o, mem_req_ready_i, mem_req_we_o;
  logic [31:0]  mem_req_addr_o;
  logic [127:0] mem_req_wdata_o;
  logic         mem_resp_valid_i;
  logic [127:0] mem_resp_rdata_i;
  logic [31:0]  hit_cnt_o, miss_cnt_o;

  always #5 clk_i = ~clk_i;

  dcache_nway_wb dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cpu_req_valid_i(cpu_req_valid_i), .cpu_req_ready_o(cpu_req_ready_o),
    .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_wstrb_i(cpu_wstrb_i), .cpu_resp_valid_o(cpu_resp_valid_o),
    .cpu_resp_ready_i(cpu_resp_ready_i), .cpu_resp_rdata_o(cpu_resp_rdata_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_we_o(mem_req_we_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_wdata_o(mem_req_wdata_o), .mem_resp_valid_i(mem_resp_valid_i),
    .mem_resp_rdata_i(mem_resp_rdata_i), .hit_cnt_o(hit_cnt_o),
    .miss_cnt_o(miss_cnt_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Backing memory: written-back lines override the default pattern.
  logic [127:0] mem_store [int unsigned];

  function automatic logic [127:0] line_for(input logic [31:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    if (a == 32'h1000) return {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    return {a ^ 32'h3, a ^ 32'h2, a ^ 32'h1, a};
  endfunction

  int           mem_delay = 0, resp_delay = 0;
  bit           abort_refill = 0, spurious = 0;
  int           rd_cnt = 0, wb_cnt = 0, stable_err = 0, got_lat;
  logic [31:0]  rd_addr, wb_addr, got_rdata;
  logic [127:0] wb_data;

  task automatic access(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb);
    int           cyc = 0, mem_wait = 0, resp_wait = 0;
    bit           new_req = 1, rdy_given = 0, resp_seen = 0, done = 0;
    logic         cur_we = 0;
    logic [31:0]  cur_addr = '0;
    logic [127:0] cur_wdata = '0;
    got_lat = -1;
    got_rdata = 'x;
    @(negedge clk_i);
    cpu_req_valid_i = 1; cpu_we_i = we; cpu_addr_i = addr;
    cpu_wdata_i = wdata; cpu_wstrb_i = strb;
    check("req_ready_idle", cpu_req_ready_o, 1);
    @(posedge clk_i);
    #1 cpu_req_valid_i = 0; cpu_we_i = 0; cpu_wdata_i = '0; cpu_wstrb_i = '0;
    while (!done && cyc < 200) begin
      @(negedge clk_i);
      cyc++;
      mem_resp_valid_i = spurious;
      mem_resp_rdata_i = '1;
      if (cpu_resp_ready_i) begin
        cpu_resp_ready_i = 0;
        done = 1;
        break;
      end
      if (rdy_given) begin
        rdy_given = 0; mem_req_ready_i = 0; new_req = 1;
        if (!cur_we) begin
          if (abort_refill) begin
            rst_ni = 0;
            #1;
            check("rst_resp_valid", cpu_resp_valid_o, 0);
            check("rst_resp_rdata", cpu_resp_rdata_o, 0);
            check("rst_mem_valid", mem_req_valid_o, 0);
            check("rst_mem_we", mem_req_we_o, 0);
            check("rst_mem_addr", mem_req_addr_o, 0);
            check("rst_mem_wdata", mem_req_wdata_o, 0);
            check("rst_hit_cnt", hit_cnt_o, 0);
            check("rst_miss_cnt", miss_cnt_o, 0);
            check("rst_req_ready", cpu_req_ready_o, 0);
            mem_resp_valid_i = 0;
            done = 1;
            break;
          end
          mem_resp_valid_i = 1;
          mem_resp_rdata_i = line_for(cur_addr);
        end
      end
      if (mem_req_valid_o) begin
        if (new_req) begin
          cur_we = mem_req_we_o; cur_addr = mem_req_addr_o; cur_wdata = mem_req_wdata_o;
          new_req = 0; mem_wait = 0;
        end else if ({mem_req_we_o, mem_req_addr_o, mem_req_wdata_o} !== {cur_we, cur_addr, cur_wdata})
          stable_err++;
        if (mem_wait < mem_delay) mem_wait++;
        else begin
          mem_req_ready_i = 1; rdy_given = 1;
          if (cur_we) begin
            wb_cnt++; wb_addr = cur_addr; wb_data = cur_wdata; mem_store[cur_addr] = cur_wdata;
          end else begin
            rd_cnt++; rd_addr = cur_addr;
          end
        end
      end else if (!new_req) stable_err++;   // request dropped before acceptance
      if (cpu_resp_valid_o) begin
        if (!resp_seen) begin
          resp_seen = 1; got_lat = cyc; got_rdata = cpu_resp_rdata_o;
        end else if (cpu_resp_rdata_o !== got_rdata) stable_err++;
        if (resp_wait < resp_delay) resp_wait++;
        else cpu_resp_ready_i = 1;
      end else if (resp_seen) stable_err++;  // response dropped before taken
    end
    mem_resp_valid_i = 0;
    if (!done) check("access_timeout", 0, 1);
  endtask

  initial begin
    rst_ni = 0;
    cpu_req_valid_i = 0; cpu_we_i = 0; cpu_addr_i = '0; cpu_wdata_i = '0; cpu_wstrb_i = '0;
    cpu_resp_ready_i = 0; mem_req_ready_i = 0; mem_resp_valid_i = 0; mem_resp_rdata_i = '0;
    repeat (3) @(negedge clk_i);
    check("reset_resp_valid", cpu_resp_valid_o, 0);
    check("reset_mem_valid", mem_req_valid_o, 0);
    check("reset_hit_cnt", hit_cnt_o, 0);
    check("reset_miss_cnt", miss_cnt_o, 0);
    rst_ni = 1;

    // Cold load miss: one refill read of the line at 0x1000.
    access(0, 32'h1004, 0, 4'h0);
    check("cold_rd_cnt", rd_cnt, 1);
    check("cold_rd_addr", rd_addr, 32'h1000);
    check("cold_rdata", got_rdata, 32'h22222222);
    check("cold_miss_cnt", miss_cnt_o, 1);
    check("cold_hit_cnt", hit_cnt_o, 0);

    // Load hit, with stray refill data that must be ignored.
    spurious = 1;
    access(0, 32'h1008, 0, 4'h0);
    spurious = 0;
    check("hit_no_mem", rd_cnt, 1);
    check("hit_rdata", got_rdata, 32'h33333333);
    check("hit_latency", got_lat, 2);
    check("hit_cnt_1", hit_cnt_o, 1);

    // Store hit with partial byte enables, then read back.
    access(1, 32'h1000, 32'hAABBCCDD, 4'b0011);
    check("store_rdata_zero", got_rdata, 0);
    check("store_latency", got_lat, 2);
    access(0, 32'h1000, 0, 4'h0);
    check("merge_rdata", got_rdata, 32'h1111CCDD);
    check("hit_cnt_3", hit_cnt_o, 3);

    // Fill way1 with 0x2000 (invalid way chosen, clean, no writeback).
    access(0, 32'h2000, 0, 4'h0);
    check("fill2_rd_addr", rd_addr, 32'h2000);
    check("fill2_rdata", got_rdata, 32'h00002000);
    check("fill2_no_wb", wb_cnt, 0);
    check("miss_cnt_2", miss_cnt_o, 2);

    // Evict dirty 0x1000 from way0 under memory and CPU backpressure.
    mem_delay = 5; resp_delay = 3;
    access(0, 32'h3000, 0, 4'h0);
    mem_delay = 0; resp_delay = 0;
    check("evict_wb_cnt", wb_cnt, 1);
    check("evict_wb_addr", wb_addr, 32'h1000);
    check("evict_wb_data", wb_data, {32'h44444444, 32'h33333333, 32'h22222222, 32'h1111CCDD});
    check("evict_rd_addr", rd_addr, 32'h3000);
    check("evict_rd_cnt", rd_cnt, 3);
    check("evict_rdata", got_rdata, 32'h00003000);
    check("evict_stable", stable_err, 0);
    check("miss_cnt_3", miss_cnt_o, 3);

    // Way1 (0x2000) survived, so 0x3000 went to way0.
    access(0, 32'h2004, 0, 4'h0);
    check("way1_kept_no_mem", rd_cnt, 3);
    check("way1_kept_rdata", got_rdata, 32'h00002001);
    check("hit_cnt_4", hit_cnt_o, 4);

    // 0x1000 was evicted; refill returns the written-back data.
    access(0, 32'h1000, 0, 4'h0);
    check("reload_rd_cnt", rd_cnt, 4);
    check("reload_rd_addr", rd_addr, 32'h1000);
    check("reload_no_wb", wb_cnt, 1);
    check("reload_rdata", got_rdata, 32'h1111CCDD);
    check("miss_cnt_4", miss_cnt_o, 4);

    // Reset while waiting for refill data.
    abort_refill = 1;
    access(0, 32'h2008, 0, 4'h0);
    abort_refill = 0;
    check("abort_rd_cnt", rd_cnt, 5);
    repeat (2) @(negedge clk_i);
    rst_ni = 1;
    access(0, 32'h1000, 0, 4'h0);
    check("post_rst_rd_cnt", rd_cnt, 6);
    check("post_rst_rd_addr", rd_addr, 32'h1000);
    check("post_rst_miss_cnt", miss_cnt_o, 1);
    check("post_rst_hit_cnt", hit_cnt_o, 0);
    check("post_rst_stable", stable_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
